// File: rtl/apb_pkg.sv
// apb_pkg: shared types and defaults for the APB initiator.
//   apb_state_e : transfer FSM states (IDLE, SETUP, ACCESS, RESP)
//   ADDR_W_DEF  : default address width
//   DATA_W_DEF  : default data width
//   WDOG_W      : width of the ACCESS wait counter
//   apb_rsp_t   : response record {rdata, slverr, timeout}, also used by
//                 bench-side monitors
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_state_e;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;
   localparam int WDOG_W     = 8;

   typedef struct packed {
      logic [DATA_W_DEF-1:0] rdata;
      logic                  slverr;
      logic                  timeout;
   } apb_rsp_t;

endpackage

// File: rtl/apb_wdog.sv
// apb_wdog: wait-state counter for the APB ACCESS phase.
// Ports:
//   pclk, preset : clock, synchronous active-high reset
//   clear        : force the count back to 0 (takes priority over inc)
//   inc          : add one to the count
//   expired      : count equals TIMEOUT
module apb_wdog
   import apb_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic pclk,
   input  logic preset,
   input  logic clear,
   input  logic inc,
   output logic expired
);

   logic [WDOG_W-1:0] cnt;

   always_ff @(posedge pclk) begin
      if (preset || clear) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = (cnt == WDOG_W'(TIMEOUT));

endmodule

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB initiator. Turns a valid/ready command
// stream into APB SETUP/ACCESS transfers and returns a registered response.
// A watchdog aborts a transfer whose pready never arrives.
// Ports:
//   pclk, preset                     : clock, synchronous active-high reset
//   cmd_valid/cmd_ready              : command handshake
//   cmd_write, cmd_addr, cmd_wdata   : command payload
//   rsp_valid/rsp_ready              : response handshake
//   rsp_rdata, rsp_slverr, rsp_timeout : response payload
//   psel, penable, pwrite, paddr, pwdata : APB request (all registered)
//   prdata, pready, pslverr          : APB completion inputs
//
// Handshake rule for both streams: a beat transfers on a rising edge where
// valid and ready are both high. cmd_ready is decoded from state only and
// never looks at cmd_valid; rsp_valid stays high with a stable payload until
// rsp_ready is seen, and rsp_ready is ignored while no response is held.
module apb_master
   import apb_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = 16
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_slverr,
   output logic              rsp_timeout,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
);

   apb_state_e state;
   logic       wd_clear;
   logic       wd_inc;
   logic       wd_expired;

   // Counter is zeroed during SETUP so it reads 0 on the first ACCESS cycle.
   // It stops at TIMEOUT; the abort happens in that same cycle.
   assign wd_clear = (state == SETUP);
   assign wd_inc   = (state == ACCESS) && !pready && !wd_expired;

   apb_wdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .pclk    (pclk),
      .preset  (preset),
      .clear   (wd_clear),
      .inc     (wd_inc),
      .expired (wd_expired)
   );

   assign cmd_ready = (state == IDLE);

   always_ff @(posedge pclk) begin
      if (preset) begin
         state       <= IDLE;
         psel        <= 1'b0;
         penable     <= 1'b0;
         pwrite      <= 1'b0;
         paddr       <= '0;
         pwdata      <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_slverr  <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  state   <= SETUP;
                  psel    <= 1'b1;
                  penable <= 1'b0;
                  pwrite  <= cmd_write;
                  paddr   <= cmd_addr;
                  pwdata  <= cmd_wdata;
               end
            end
            SETUP: begin
               state   <= ACCESS;
               penable <= 1'b1;
            end
            ACCESS: begin
               // A real completion wins over an expiry in the same cycle.
               if (pready) begin
                  state       <= RESP;
                  psel        <= 1'b0;
                  penable     <= 1'b0;
                  rsp_valid   <= 1'b1;
                  rsp_rdata   <= pwrite ? '0 : prdata;
                  rsp_slverr  <= pslverr;
                  rsp_timeout <= 1'b0;
               end else if (wd_expired) begin
                  state       <= RESP;
                  psel        <= 1'b0;
                  penable     <= 1'b0;
                  rsp_valid   <= 1'b1;
                  rsp_rdata   <= '0;
                  rsp_slverr  <= 1'b1;
                  rsp_timeout <= 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
